fetch_unit: RTL

Instruction fetch stage sitting directly upstream of decode/execute in the mini-CPU. It owns the fetch PC, issues reads to a synchronous 1-cycle-latency instruction memory, and buffers returned instructions, each tagged with its PC, in a small prefetch FIFO. It presents them to decode over a valid/ready handshake. A redirect input flushes the buffer and any in-flight read and restarts fetch at a new PC.

---
 rtl/fetch_unit_if.sv | 69 ++++++
 rtl/fetch_unit.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/fetch_unit_if.sv
// fetch_unit_if
//
// Bundles everything the fetch stage exchanges with the outside world
// except clock and reset: the instruction-memory read port, the redirect
// input from execute, and the valid/ready instruction stream to decode.
//
// Ports (as seen by the fetch unit through the master modport):
//   imem_req        out  read request this cycle
//   imem_addr       out  read address (the fetch PC)
//   imem_rdata      in   read data, valid the cycle after a request
//   redirect_valid  in   flush and restart fetch at redirect_pc
//   redirect_pc     in   new fetch PC
//   out_valid       out  FIFO head holds a valid instruction
//   out_ready       in   decode accepts the head this cycle
//   out_instr       out  head instruction
//   out_pc          out  PC of the head instruction
//   fifo_count      out  current FIFO occupancy
//
// The slave modport is the mirror image, used by whatever drives the
// memory, redirect and decode side.

interface fetch_unit_if #(
    parameter int PC_W    = 8,
    parameter int INSTR_W = 16,
    parameter int DEPTH   = 4
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic               imem_req;
    logic [PC_W-1:0]    imem_addr;
    logic [INSTR_W-1:0] imem_rdata;

    logic               redirect_valid;
    logic [PC_W-1:0]    redirect_pc;

    logic               out_valid;
    logic               out_ready;
    logic [INSTR_W-1:0] out_instr;
    logic [PC_W-1:0]    out_pc;
    logic [CNT_W-1:0]   fifo_count;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        input  redirect_valid,
        input  redirect_pc,
        output out_valid,
        input  out_ready,
        output out_instr,
        output out_pc,
        output fifo_count
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        output redirect_valid,
        output redirect_pc,
        input  out_valid,
        output out_ready,
        input  out_instr,
        input  out_pc,
        input  fifo_count
    );

endinterface

// File: rtl/fetch_unit.sv
// fetch_unit
//
// Instruction fetch stage. Owns the fetch PC, issues reads to a
// synchronous 1-cycle-latency instruction memory, and buffers each
// returned instruction together with its PC in a small prefetch FIFO
// that feeds decode over a valid/ready handshake. A redirect flushes the
// FIFO and any in-flight read and restarts fetch at a new PC.
//
// Ports:
//   clk  in  clock, all state updates on the rising edge
//   rst  in  asynchronous active-high reset
//   bus  fetch_unit_if.master: memory read port, redirect input,
//        decode-side valid/ready stream and FIFO occupancy
//
// Parameters:
//   PC_W     fetch PC / memory address width
//   INSTR_W  instruction width
//   DEPTH    prefetch FIFO entries (power of 2, at least 4)

module fetch_unit #(
    parameter int PC_W    = 8,
    parameter int INSTR_W = 16,
    parameter int DEPTH   = 4
) (
    input  logic          clk,
    input  logic          rst,
    fetch_unit_if.master  bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    // Architectural state
    logic [PC_W-1:0]    fpc_q, fpc_d;
    logic               inflight_q, inflight_d;
    logic [PC_W-1:0]    inflight_pc_q, inflight_pc_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [INSTR_W-1:0] instr_mem_q [DEPTH];
    logic [INSTR_W-1:0] instr_mem_d [DEPTH];
    logic [PC_W-1:0]    pc_mem_q    [DEPTH];
    logic [PC_W-1:0]    pc_mem_d    [DEPTH];

    // Per-cycle control
    logic               req;
    logic               push;
    logic               pop;
    logic               head_valid;
    logic [CNT_W:0]     credits_used;

    // Credit check: a slot is reserved for every buffered entry and for
    // the read already in flight, so a new request is only issued when
    // its response is guaranteed a place in the FIFO. This is what makes
    // overflow impossible without any response-side stalling.
    always_comb begin
        credits_used = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q};
        req          = !rst && !bus.redirect_valid
                       && (credits_used < (CNT_W + 1)'(DEPTH));
        head_valid   = (count_q != '0);
        push         = inflight_q && !bus.redirect_valid;
        pop          = head_valid && bus.out_ready;
    end

    // Next-state logic. A redirect overrides everything: the FIFO is
    // emptied, any response arriving this cycle is dropped, and fetch
    // restarts at the redirect target. A pop in the same cycle still
    // completes its handshake on the decode side, but the flush leaves
    // the FIFO empty regardless.
    always_comb begin
        fpc_d         = fpc_q;
        inflight_d    = req;
        inflight_pc_d = inflight_pc_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        instr_mem_d   = instr_mem_q;
        pc_mem_d      = pc_mem_q;

        if (bus.redirect_valid) begin
            fpc_d      = bus.redirect_pc;
            inflight_d = 1'b0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (req) begin
                fpc_d         = fpc_q + 1'b1;
                inflight_pc_d = fpc_q;
            end
            if (push) begin
                instr_mem_d[wr_ptr_q] = bus.imem_rdata;
                pc_mem_d[wr_ptr_q]    = inflight_pc_q;
                wr_ptr_d              = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // State register. Reset is asynchronous so that asserting it in the
    // middle of operation clears the outputs without waiting for a clock
    // edge; the FIFO storage is cleared too so the head reads as zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fpc_q         <= '0;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                instr_mem_q[i] <= '0;
                pc_mem_q[i]    <= '0;
            end
        end else begin
            fpc_q         <= fpc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            instr_mem_q   <= instr_mem_d;
            pc_mem_q      <= pc_mem_d;
        end
    end

    // Outputs. The decode side only ever sees registered FIFO contents;
    // there is deliberately no bypass path from imem_rdata. The head is
    // masked while the FIFO is empty so stale entries left behind by a
    // flush or a drain never appear on the bus.
    always_comb begin
        bus.imem_req   = req;
        bus.imem_addr  = fpc_q;
        bus.out_valid  = head_valid;
        bus.out_instr  = head_valid ? instr_mem_q[rd_ptr_q] : '0;
        bus.out_pc     = head_valid ? pc_mem_q[rd_ptr_q] : '0;
        bus.fifo_count = count_q;
    end

    // The credit check should make a push into a full FIFO unreachable;
    // flag it in simulation if that reasoning is ever broken.
    no_overflow: assert property (
        @(posedge clk) disable iff (rst)
        !(push && (count_q == CNT_W'(DEPTH)))
    );

endmodule
